// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: multiplexed active-low seven-segment display bus
interface seg_scan_decoder_if #(parameter int NDIG = 4);
    logic [0:6]      seg_n;
    logic [NDIG-1:0] an_n;
    modport master (output seg_n, an_n);
    modport slave  (input  seg_n, an_n);
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a scanned seven-segment bus and rebuilds per-digit hex nibbles
module seg_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_decoder_if.slave     bus,
    input  logic                  clr,
    output logic [4*NDIG-1:0]     digits,
    output logic [NDIG-1:0]       dig_valid,
    output logic                  upd,
    output logic [2:0]            upd_idx,
    output logic                  bad_pat
);
    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
    state_t          state_q, state_d;
    logic [0:6]      seg1_q, seg2_q, pseg_q;
    logic [NDIG-1:0] an1_q, an2_q, pan_q;
    logic [7:0]      cnt_q, cnt_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0] valid_q, valid_d;
    logic            upd_q, upd_d, bad_q, bad_d;
    logic [2:0]      idx_q, idx_d, sel_idx;
    logic            sel_ok, same, commit;
    logic [4:0]      dec;

    function automatic logic [4:0] decode(input logic [0:6] s);
        case (s)
            7'h01: decode = 5'h10; 7'h4F: decode = 5'h11; 7'h12: decode = 5'h12; 7'h06: decode = 5'h13;
            7'h4C: decode = 5'h14; 7'h24: decode = 5'h15; 7'h20: decode = 5'h16; 7'h0F: decode = 5'h17;
            7'h00: decode = 5'h18; 7'h04: decode = 5'h19; 7'h08: decode = 5'h1A; 7'h60: decode = 5'h1B;
            7'h31: decode = 5'h1C; 7'h42: decode = 5'h1D; 7'h30: decode = 5'h1E; 7'h38: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign sel_ok = $onehot(~an2_q);
    assign same   = {seg2_q, an2_q} == {pseg_q, pan_q};
    assign dec    = decode(seg2_q);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NDIG; i++) if (!an2_q[i]) sel_idx = 3'(i);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = sel_ok ? SETTLE : IDLE;
                cnt_d   = sel_ok ? 8'd1 : 8'd0;
            end
            SETTLE: begin
                cnt_d   = !sel_ok ? 8'd0 : !same ? 8'd1 : (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                commit  = sel_ok && cnt_d == 8'(STABLE);
                state_d = !sel_ok ? IDLE : commit ? LOCKED : SETTLE;
            end
            LOCKED: begin
                state_d = same ? LOCKED : sel_ok ? SETTLE : IDLE;
                cnt_d   = same ? cnt_q : sel_ok ? 8'd1 : 8'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // a commit landing with clr is applied after the clear so its flag survives
    always_comb begin
        upd_d    = commit & dec[4];
        bad_d    = (bad_q & ~clr) | (commit & ~dec[4]);
        idx_d    = upd_d ? sel_idx : idx_q;
        valid_d  = clr ? '0 : valid_q;
        digits_d = digits_q;
        for (int i = 0; i < NDIG; i++) begin
            if (upd_d && sel_idx == 3'(i)) begin
                digits_d[4*i +: 4] = dec[3:0];
                valid_d[i]         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg1_q   <= '1;
            seg2_q   <= '1;
            pseg_q   <= '1;
            an1_q    <= '1;
            an2_q    <= '1;
            pan_q    <= '1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            upd_q    <= 1'b0;
            idx_q    <= '0;
            bad_q    <= 1'b0;
        end else begin
            seg1_q   <= bus.seg_n;
            seg2_q   <= seg1_q;
            pseg_q   <= seg2_q;
            an1_q    <= bus.an_n;
            an2_q    <= an1_q;
            pan_q    <= an2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            upd_q    <= upd_d;
            idx_q    <= idx_d;
            bad_q    <= bad_d;
        end
    end

    assign digits    = digits_q;
    assign dig_valid = valid_q;
    assign upd       = upd_q;
    assign upd_idx   = idx_q;
    assign bad_pat   = bad_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: table-driven and directed checks of the seven-segment scan decoder
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] digits;
    logic [3:0]  dig_valid;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        bad_pat;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          upd_cnt = 0;

    seg_scan_decoder_if #(.NDIG(4)) bus_if ();

    seg_scan_decoder #(.NDIG(4), .STABLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if.slave), .clr(clr),
        .digits(digits), .dig_valid(dig_valid), .upd(upd), .upd_idx(upd_idx), .bad_pat(bad_pat)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (upd) upd_cnt++;

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  an;
        logic        c;
        int          cyc;
        int          n_upd;
        logic [15:0] dig;
        logic [3:0]  val;
        logic [2:0]  idx;
        logic        bad;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] a, input logic c, input int n);
        bus_if.seg_n = s;
        bus_if.an_n  = a;
        clr = c;
        @(negedge clk);
        clr = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        logic [6:0] codes [16];
        vec_t       tbl [22];
        int         u0;
        codes = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        for (int i = 0; i < 16; i++)
            tbl[i] = '{codes[i], 4'b1011, 1'b0, 10, 1, 16'h0002 | (16'(i) << 8), 4'b0101, 3'd2, 1'b0};
        tbl[16] = '{7'h7F, 4'b1110, 1'b0, 8, 0, 16'h0F02, 4'b0101, 3'd2, 1'b1};
        tbl[17] = '{7'h7F, 4'b1110, 1'b1, 3, 0, 16'h0F02, 4'b0000, 3'd2, 1'b0};
        tbl[18] = '{7'h4F, 4'b0111, 1'b0, 8, 1, 16'h1F02, 4'b1000, 3'd3, 1'b0};
        tbl[19] = '{7'h01, 4'b1100, 1'b0, 8, 0, 16'h1F02, 4'b1000, 3'd3, 1'b0};
        tbl[20] = '{7'h01, 4'b1111, 1'b0, 8, 0, 16'h1F02, 4'b1000, 3'd3, 1'b0};
        tbl[21] = '{7'h01, 4'b0111, 1'b0, 8, 1, 16'h0F02, 4'b1000, 3'd3, 1'b0};

        bus_if.seg_n = 7'h7F;
        bus_if.an_n  = 4'hF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(7'h06, 4'b1110, 1'b0, 10);
        chk("pre_reset_digits", 32'(digits), 32'h0003);
        chk("pre_reset_valid", 32'(dig_valid), 32'h1);
        bus_if.seg_n = 7'h12;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_digits", 32'(digits), 32'h0);
        chk("async_rst_valid", 32'(dig_valid), 32'h0);
        chk("async_rst_upd", 32'(upd), 32'h0);
        chk("async_rst_idx", 32'(upd_idx), 32'h0);
        chk("async_rst_bad", 32'(bad_pat), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        u0 = upd_cnt;
        repeat (10) @(negedge clk);
        chk("post_rst_digits", 32'(digits), 32'h0002);
        chk("post_rst_valid", 32'(dig_valid), 32'h1);
        chk("post_rst_upds", 32'(upd_cnt - u0), 32'd1);
        chk("post_rst_idx", 32'(upd_idx), 32'd0);

        for (int i = 0; i < 22; i++) begin
            u0 = upd_cnt;
            hold(tbl[i].seg, tbl[i].an, tbl[i].c, tbl[i].cyc);
            chk($sformatf("v%0d_upds", i), 32'(upd_cnt - u0), 32'(tbl[i].n_upd));
            chk($sformatf("v%0d_digits", i), 32'(digits), 32'(tbl[i].dig));
            chk($sformatf("v%0d_valid", i), 32'(dig_valid), 32'(tbl[i].val));
            chk($sformatf("v%0d_idx", i), 32'(upd_idx), 32'(tbl[i].idx));
            chk($sformatf("v%0d_bad", i), 32'(bad_pat), 32'(tbl[i].bad));
        end

        hold(7'h01, 4'b1111, 1'b0, 5);
        u0 = upd_cnt;
        hold(7'h06, 4'b1101, 1'b0, 3);
        hold(7'h01, 4'b1111, 1'b0, 10);
        chk("glitch_upds", 32'(upd_cnt - u0), 32'd0);
        u0 = upd_cnt;
        bus_if.seg_n = 7'h24;
        bus_if.an_n  = 4'b1101;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            chk($sformatf("latency_j%0d", j), 32'(upd), 32'(j == 6));
        end
        repeat (100) @(negedge clk);
        chk("long_hold_upds", 32'(upd_cnt - u0), 32'd1);
        chk("long_hold_digits", 32'(digits), 32'h0F52);
        chk("long_hold_valid", 32'(dig_valid), 32'b1010);

        bus_if.seg_n = 7'h12;
        bus_if.an_n  = 4'b0111;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 5) clr = 1'b1;
        end
        clr = 1'b0;
        chk("clr_commit_upd", 32'(upd), 32'h1);
        chk("clr_commit_valid", 32'(dig_valid), 32'b1000);
        chk("clr_commit_digits", 32'(digits), 32'h2F52);
        chk("clr_commit_idx", 32'(upd_idx), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder. It samples a multiplexed, active-low seven-segment bus (segment lines plus one-hot active-low digit anodes) and rebuilds the hex nibble shown on each digit. It applies a stability filter and flags illegal patterns. It sits in the test/monitor path, so a bench or on-chip checker can read back what the display is actually showing.

## Interface
Parameters:
- NDIG, 4: number of multiplexed digits (1..8).
- STABLE, 4: consecutive identical synchronized samples required before commit (2..255).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- seg_n  in  [0:6]  segment lines, active-low; seg_n[0]=a … seg_n[6]=g; may be asynchronous to clk.
- an_n  in  NDIG  digit anodes, active-low, at most one low at a time when legal; may be asynchronous.
- clr  in  1  synchronous clear of dig_valid and bad_pat.
- digits  out  4*NDIG  decoded nibbles; digit i at [4i+3:4i].
- dig_valid  out  NDIG  bit i set once digit i has been committed since reset/clr.
- upd  out  1  one-cycle strobe on each successful commit.
- upd_idx  out  3  index of the digit committed with upd; holds its last value otherwise.
- bad_pat  out  1  sticky; a stable, legally selected pattern was not one of the 16 codes.

## Operation
- Input path: seg_n and an_n pass through a two-flop synchronizer. All decisions use stage-2 values (s_seg, s_an).
- Decode table (seg_n[0] is the MSB of the 7-bit value): 01→0, 4F→1, 12→2, 06→3, 4C→4, 24→5, 20→6, 0F→7, 00→8, 04→9, 08→A, 60→B, 31→C, 42→D, 30→E, 38→F. Any other value is illegal.
- Anode legality: exactly one bit of s_an is low. All-high (blanking) and multiple-low are both "no select".
- FSM:
  - IDLE: no select. Counter held at 0. Go to SETTLE when a legal select appears.
  - SETTLE: if (s_seg, s_an) equals the previous sample, increment the counter; otherwise reload it to 1. If the select becomes illegal, go to IDLE. When the counter reaches STABLE, commit and go to LOCKED.
  - LOCKED: hold with no further commits. Any change in s_seg or s_an goes to SETTLE with the counter at 1, or to IDLE if the select is illegal.
- Commit for a legal code:
  - digits[idx] gets the nibble.
  - dig_valid[idx] is set.
  - upd pulses and upd_idx is set to idx.
- Commit for an illegal code:
  - bad_pat is set.
  - digits, dig_valid, upd and upd_idx are unchanged.
- Exactly one commit happens per stable period, regardless of how long the pattern is held.
- clr clears dig_valid and bad_pat. If a commit occurs in the same cycle, it is applied after the clear, so its bit or bad_pat ends up set.
- Counter width is 8 bits and it saturates. It cannot wrap before reaching STABLE.

## Timing
- Reset values:
  - digits = 0, dig_valid = 0, upd = 0, upd_idx = 0, bad_pat = 0.
  - Synchronizers reset to all-ones (blank).
  - FSM in IDLE, counter at 0.
- Latency: the input changes before edge k and is then held. upd is high in the cycle after edge k+STABLE+1; with STABLE=4, upd goes high after edge k+5.
- digits, dig_valid and upd_idx update on the same edge that raises upd.
- Any glitch shorter than STABLE samples restarts the count; no commit occurs.
- Asserting rst_n low mid-SETTLE clears everything immediately, with no clock required. After release, capture restarts from IDLE.

## Test plan
- Reset: assert rst_n low mid-stream → all outputs 0 asynchronously; hold an_n=1110, seg_n=7'h12 after release → digits[3:0]=2, dig_valid=0001, upd once, upd_idx=0.
- Scan all 16 codes on digit 2 (an_n=1011), each held 10 cycles → 16 upd pulses, digits[11:8] follows 0..F, upd_idx=2, bad_pat=0.
- Stability: hold a code on digit 1 for 3 cycles, then change it → no upd. Hold 4 cycles → exactly one upd at edge k+5; keep holding 100 cycles → still one upd.
- Illegal pattern: an_n=1110, seg_n=7'h7F held 8 cycles → bad_pat=1, no upd, dig_valid unchanged. Then pulse clr → bad_pat=0.
- Illegal select: an_n=1100 or 1111 with seg_n=7'h01 → no commits, FSM IDLE. Then an_n=0111 → digits[15:12]=0, dig_valid[3]=1.
- clr coincident with a commit on digit 3 → dig_valid=1000 after that edge; all other bits cleared.
